aes_dec_key_sched: RTL

- Sequential AES-128 key schedule that sits directly upstream of the inverse (decryption) round datapath and supplies its per-round 128-bit round key.
- Takes the cipher key, expands it forward one round key per cycle, and buffers all 11 round keys.
- Serves the keys through a registered indexed read port, so the decryption controller can fetch them in reverse order (10 down to 0).

---
 rtl/aes_dec_key_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/aes_dec_key_sched.sv
// AES-128 key schedule with an 11-entry round-key store and a registered indexed read port.
// Optional macro AES_KEY_SCHED_ONESHOT_EN: a successful read of round key 0 zeroizes the store.
module aes_dec_key_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } state_e;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic [127:0]   rk_q [0:NR];
  logic           rd_valid_q, rd_err_q;
  logic [127:0]   rd_key_q;

  logic           wr_en;
  logic [3:0]     wr_idx;
  logic [127:0]   wr_data;
  logic           store_clr;
  logic           rd_hit;

  // One forward expansion step from the previous round key held in work_q.
  logic [31:0]    w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [127:0]   next_rk;

  always_comb begin
    {w0, w1, w2, w3} = work_q;
    t       = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(cnt_q), 24'h0};
    n0      = w0 ^ t;
    n1      = w1 ^ n0;
    n2      = w2 ^ n1;
    n3      = w3 ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    wr_en     = 1'b0;
    wr_idx    = cnt_q;
    wr_data   = next_rk;
    store_clr = 1'b0;
    if (key_load) begin
      state_d = ST_EXPAND;
      cnt_d   = 4'd1;
      work_d  = key_in;
      wr_en   = 1'b1;
      wr_idx  = 4'd0;
      wr_data = key_in;
    end else begin
      case (state_q)
        ST_EXPAND: begin
          wr_en  = 1'b1;
          work_d = next_rk;
          if (cnt_q == 4'(NR)) state_d = ST_READY;
          else                 cnt_d   = cnt_q + 4'd1;
        end
        ST_READY: begin
`ifdef AES_KEY_SCHED_ONESHOT_EN
          if (rd_en && rd_idx == 4'd0) begin
            store_clr = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = 4'd0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // NOTE: the key store is reset explicitly so no key material survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (store_clr) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (wr_en) begin
      rk_q[wr_idx] <= wr_data;
    end
  end

  // A read collides with key_load as a not-ready read; key_load always wins.
  assign rd_hit = !key_load && (state_q == ST_READY) && (rd_idx <= 4'(NR));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_q   <= '0;
    end else if (rd_en) begin
      rd_valid_q <= 1'b1;
      rd_err_q   <= !rd_hit;
      rd_key_q   <= rd_hit ? rk_q[rd_idx] : '0;
    end else begin
      rd_valid_q <= 1'b0;
    end
  end

  assign key_ready = (state_q == ST_READY);
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign rd_key    = rd_key_q;

endmodule
